// File: rtl/neuron_accumulator_if.sv
// Handshake bundle between the multiplier array, the neuron accumulator and
// the activation stage. The master side feeds products and drains sums.
interface neuron_accumulator_if #(
   parameter int unsigned N_TERMS = 33,
   parameter int unsigned WIDTH   = 32
);
   logic                            in_valid;
   logic                            in_ready;
   logic [N_TERMS-1:0][WIDTH-1:0]   products;
   logic                            out_valid;
   logic                            out_ready;
   logic [WIDTH-1:0]                sum;
   logic                            overflow;

   modport master (
      output in_valid, products, out_ready,
      input  in_ready, out_valid, sum, overflow
   );

   modport slave (
      input  in_valid, products, out_ready,
      output in_ready, out_valid, sum, overflow
   );
endinterface

// File: rtl/neuron_accumulator.sv
// Serial neuron accumulator: captures a bundle of N_TERMS signed products,
// adds one term per cycle into a wide accumulator and presents the
// saturated WIDTH-bit sum under a valid/ready handshake.
// Optional macro NEURON_RELU_EN clamps negative saturated results to zero.
module neuron_accumulator #(
   parameter int unsigned N_TERMS   = 33,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ACC_WIDTH = 38
) (
   input  logic                 clk,
   input  logic                 rst_n,
   neuron_accumulator_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(N_TERMS);

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [N_TERMS-1:0][WIDTH-1:0]   bank_q;
   logic signed [ACC_WIDTH-1:0]     acc_q;
   logic [IDX_W-1:0]                idx_q;
   logic [WIDTH-1:0]                sum_q;
   logic                            ovf_q;

   logic [WIDTH-1:0]                term;
   logic signed [ACC_WIDTH-1:0]     acc_next;
   logic                            last_term;
   logic [WIDTH-1:0]                sat_val;
   logic                            sat_ovf;
   logic [WIDTH-1:0]                res_val;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and handshake outputs
   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = ACCUM;
         end
         ACCUM: begin
            if (last_term) state_d = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Next accumulator value and saturation of the final sum
   always_comb begin
      term      = bank_q[idx_q];
      acc_next  = acc_q + {{(ACC_WIDTH-WIDTH){term[WIDTH-1]}}, term};
      last_term = (idx_q == IDX_W'(N_TERMS-1));
      sat_ovf   = 1'b0;
      sat_val   = acc_next[WIDTH-1:0];
      if (acc_next > SAT_MAX) begin
         sat_val = {1'b0, {(WIDTH-1){1'b1}}};
         sat_ovf = 1'b1;
      end else if (acc_next < SAT_MIN) begin
         sat_val = {1'b1, {(WIDTH-1){1'b0}}};
         sat_ovf = 1'b1;
      end
`ifdef NEURON_RELU_EN
      res_val = sat_val[WIDTH-1] ? '0 : sat_val;
`else
      res_val = sat_val;
`endif
   end

   // Capture bank, accumulator, term index and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q <= '0;
         acc_q  <= '0;
         idx_q  <= '0;
         sum_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  bank_q <= bus.products;
                  acc_q  <= '0;
                  idx_q  <= '0;
               end
            end
            ACCUM: begin
               acc_q <= acc_next;
               idx_q <= idx_q + 1'b1;
               if (last_term) begin
                  sum_q <= res_val;
                  ovf_q <= sat_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sum      = sum_q;
   assign bus.overflow = ovf_q;

endmodule
